// File: rtl/aibcr3_dcc_crs_gryctrl.sv
// aibcr3_dcc_crs_gryctrl: vote-filtered saturating 8-bit coarse code stepper with lock/saturation
// reporting and a registered Gray-coded copy for the coarse delay line.   Rev 1.0
`default_nettype none

module aibcr3_dcc_crs_gryctrl #(
  parameter int         FILT_LEN  = 4,
  parameter int         LOCK_CNT  = 3,
  parameter logic [7:0] INIT_CODE = 8'd128
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        PD_VLD,
  input  logic        PD_UP,
  output logic [7:0]  CRS_BIN,
  output logic [10:3] GRY_OUT,
  output logic        LOCK,
  output logic        SAT
);

  localparam logic [3:0] FILT_W = 4'(FILT_LEN);
  localparam logic [3:0] LOCK_W = 4'(LOCK_CNT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TRACK  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic       vdir, vdir_nxt;
  logic [3:0] vcnt, vcnt_nxt;
  logic       pdir, pdir_nxt;
  logic       pvld, pvld_nxt;
  logic       same2, same2_nxt;
  logic [3:0] rcnt, rcnt_nxt;
  logic [7:0] crs_nxt;
  logic       sat_nxt;
  logic [3:0] vinc;
  logic       step;
  logic       at_limit;

  always_comb begin
    state_nxt = state;
    vdir_nxt  = vdir;
    vcnt_nxt  = vcnt;
    pdir_nxt  = pdir;
    pvld_nxt  = pvld;
    same2_nxt = same2;
    rcnt_nxt  = rcnt;
    crs_nxt   = CRS_BIN;
    sat_nxt   = SAT;
    step      = 1'b0;
    vinc      = (PD_UP == vdir) ? 4'(vcnt + 4'd1) : 4'd1;
    at_limit  = PD_UP ? (CRS_BIN == 8'hFF) : (CRS_BIN == 8'h00);

    if (!EN || state == S_IDLE) begin
      // Disabled or just re-enabled: discard all filter and lock progress.
      state_nxt = EN ? S_TRACK : S_IDLE;
      vcnt_nxt  = 4'd0;
      rcnt_nxt  = 4'd0;
      pvld_nxt  = 1'b0;
      same2_nxt = 1'b0;
    end else begin
      if (PD_VLD) begin
        vdir_nxt = PD_UP;
        if (vinc == FILT_W) begin
          step     = 1'b1;
          vcnt_nxt = 4'd0;
        end else begin
          vcnt_nxt = vinc;
        end
      end

      if (step) begin
        if (at_limit) begin
          sat_nxt = 1'b1;
        end else begin
          crs_nxt = PD_UP ? 8'(CRS_BIN + 8'd1) : 8'(CRS_BIN - 8'd1);
          sat_nxt = 1'b0;
          if (!pvld) begin
            pdir_nxt = PD_UP;
            pvld_nxt = 1'b1;
          end else if (PD_UP != pdir) begin
            pdir_nxt  = PD_UP;
            same2_nxt = 1'b0;
            if (rcnt != 4'hF) rcnt_nxt = 4'(rcnt + 4'd1);
            if (rcnt_nxt >= LOCK_W) state_nxt = S_LOCKED;
          end else begin
            rcnt_nxt = 4'd0;
            if (state == S_LOCKED && same2) begin
              state_nxt = S_TRACK;
              same2_nxt = 1'b0;
            end else begin
              same2_nxt = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      vdir    <= 1'b0;
      vcnt    <= 4'd0;
      pdir    <= 1'b0;
      pvld    <= 1'b0;
      same2   <= 1'b0;
      rcnt    <= 4'd0;
      CRS_BIN <= INIT_CODE;
      GRY_OUT <= INIT_CODE ^ (INIT_CODE >> 1);
      LOCK    <= 1'b0;
      SAT     <= 1'b0;
    end else begin
      state   <= state_nxt;
      vdir    <= vdir_nxt;
      vcnt    <= vcnt_nxt;
      pdir    <= pdir_nxt;
      pvld    <= pvld_nxt;
      same2   <= same2_nxt;
      rcnt    <= rcnt_nxt;
      CRS_BIN <= crs_nxt;
      GRY_OUT <= CRS_BIN ^ (CRS_BIN >> 1);
      LOCK    <= (state_nxt == S_LOCKED);
      SAT     <= sat_nxt;
    end
  end

endmodule

`default_nettype wire
